sprot_bus_arbiter: RTL and testbench
====================================

// Module: sprot_bus_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer sharing one sprot bus (sprot_if) among NUM_REQ requesters.
//  Grants ownership to one requester at a time and holds the grant until the owner's transfer
//  completes (bus_done) or the owner withdraws its request. Sits between requester agents/masters
//  and the single sprot_if instance; drives the bus-select mux and per-requester grants.
// PARAMETERS
//  NUM_REQ   4    number of requesters (2..16)
//  MAX_HOLD  255  cycles an owner may hold the bus before forced release (timeout build only)
// PORTS
//  clk          in   1                  bus clock; all logic on posedge
//  rst          in   1                  synchronous, active-high reset
//  req          in   NUM_REQ            per-requester request, level, held until granted/served
//  bus_done     in   1                  single-cycle pulse: current sprot transfer finished
//  gnt          out  NUM_REQ            one-hot grant, registered
//  gnt_id       out  $clog2(NUM_REQ)    index of current owner (valid while bus_busy)
//  bus_busy     out  1                  bus currently owned
//  timeout_err  out  1                  single-cycle pulse on forced release (timeout build only)
// BEHAVIOUR
//  - Reset (sync, active-high): gnt=0, gnt_id=0, bus_busy=0, timeout_err=0, rr_ptr=0, state=IDLE.
//    Reset asserted mid-ownership clears the grant on the next posedge; no done/err pulse emitted.
//  - FSM (sprot_arb_state_e): IDLE -> OWN -> RELEASE -> IDLE.
//    IDLE: if |req, pick winner = first set bit at or after rr_ptr (wrapping); at that edge set
//      gnt[winner]=1, gnt_id=winner, bus_busy=1, go OWN. Latency: req at cycle t -> gnt at t+1.
//    OWN: stay while req[gnt_id]=1 and bus_done=0. On bus_done=1 or req[gnt_id]=0: clear gnt and
//      bus_busy, rr_ptr <= gnt_id+1 (mod NUM_REQ), go RELEASE. bus_done and req drop together
//      = one release (no double ptr update). bus_done while IDLE/RELEASE is ignored.
//    RELEASE: one dead cycle, no grant (bus turnaround); unconditionally -> IDLE.
//  - Back-to-back: min grant-to-grant spacing 3 cycles (OWN exit, RELEASE, IDLE pick).
//  - Fairness: a continuously requesting requester is granted within NUM_REQ-1 other ownerships.
//  - gnt is always one-hot or zero; gnt_id stays at last owner when idle.
//  - Requests from non-owners during OWN are held, not lost (level-sensitive).
// CONFIGURATION
//  - Macro SPROT_ARB_TIMEOUT_EN defined: hold counter cleared on OWN entry, +1 per OWN cycle;
//    when count == MAX_HOLD and no release condition, force release exactly as bus_done would,
//    pulse timeout_err for one cycle, rr_ptr advances past offender. Counter width $clog2(MAX_HOLD+1).
//  - Undefined: no counter instantiated, timeout_err tied 0, ownership unbounded.
// STRUCTURE
//  - sprot_pkg: typedef enum logic [1:0] sprot_arb_state_e {ARB_IDLE, ARB_OWN, ARB_RELEASE};
//    localparam SPROT_MAX_REQ = 16.
//  - Sub-module sprot_rr_pick: combinational rotate/priority-encode (req, rr_ptr -> winner, any);
//    parameterised by NUM_REQ; arbiter FSM and registers stay in this module.
// TESTING
//  1. Single req[2]=1 from IDLE at t -> gnt=4'b0100, gnt_id=2, bus_busy=1 at t+1; bus_done at t+5
//     -> gnt=0 at t+6, RELEASE t+6, IDLE t+7.
//  2. req=4'b1111 held, bus_done 2 cycles after each grant -> grant order 0,1,2,3,0; spacing 3 cycles.
//  3. req[1] drops while owner (no bus_done) -> gnt clears next edge, rr_ptr=2; with req=4'b0011
//     held next winner is 0 (wrap).
//  4. bus_done and req[gnt_id] drop same cycle -> single release, rr_ptr advances by exactly one.
//  5. rst=1 during OWN -> all outputs 0 next edge; after rst drop with req=4'b1000 -> gnt_id=3.
//  6. SPROT_ARB_TIMEOUT_EN, MAX_HOLD=8, owner never sends bus_done -> timeout_err pulses one cycle
//     on forced release, gnt clears; without macro, grant persists for 100+ cycles, timeout_err=0.

Source files
------------

// File: rtl/sprot_pkg.sv
// ---------------------------------------------------------------------------
// sprot_pkg
// Shared types and constants for the sprot bus arbiter slice.
//   sprot_arb_state_e : arbiter FSM state encoding (IDLE -> OWN -> RELEASE)
//   SPROT_MAX_REQ     : largest supported requester count
// ---------------------------------------------------------------------------
package sprot_pkg;

  localparam int SPROT_MAX_REQ = 16;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_OWN     = 2'd1,
    ARB_RELEASE = 2'd2
  } sprot_arb_state_e;

endpackage

// File: rtl/sprot_rr_pick.sv
// ---------------------------------------------------------------------------
// sprot_rr_pick
// Combinational round-robin picker: returns the first asserted request at or
// after rr_ptr, wrapping around the request vector.
// Ports:
//   req     in   NUM_REQ  request vector
//   rr_ptr  in   IDW      highest-priority index this round (< NUM_REQ)
//   winner  out  IDW      selected index (don't care when any=0)
//   any     out  1        at least one request asserted
// ---------------------------------------------------------------------------
module sprot_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [IDW-1:0]     winner,
  output logic               any
);

  // idx_at[gi] is the requester index sitting gi places after rr_ptr.
  logic [IDW-1:0]     idx_at [NUM_REQ];
  logic [NUM_REQ-1:0] rot_req;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    logic [IDW:0] sum;
    assign sum         = {1'b0, rr_ptr} + (IDW+1)'(gi);
    assign idx_at[gi]  = (sum >= (IDW+1)'(NUM_REQ)) ? IDW'(sum - (IDW+1)'(NUM_REQ))
                                                    : IDW'(sum);
    assign rot_req[gi] = req[idx_at[gi]];
  end

  // Scan from the farthest offset down so the nearest asserted one wins.
  always_comb begin
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot_req[i]) winner = idx_at[i];
    end
  end

  assign any = |req;

endmodule

// File: rtl/sprot_bus_arbiter.sv
// ---------------------------------------------------------------------------
// sprot_bus_arbiter
// Round-robin arbiter/sequencer sharing one sprot bus among NUM_REQ masters.
// A grant is held until the owner's transfer completes (bus_done) or the
// owner drops its request, followed by one dead turnaround cycle.
// Ports:
//   clk          in   1        bus clock, posedge
//   rst          in   1        synchronous active-high reset
//   req          in   NUM_REQ  level requests
//   bus_done     in   1        pulse: current transfer finished
//   gnt          out  NUM_REQ  one-hot grant (registered)
//   gnt_id       out  IDW      current/last owner index
//   bus_busy     out  1        bus owned
//   timeout_err  out  1        pulse on forced release
// Build option: define SPROT_ARB_TIMEOUT_EN to bound ownership to MAX_HOLD+1
// cycles; otherwise timeout_err is tied low and ownership is unbounded.
// ---------------------------------------------------------------------------
module sprot_bus_arbiter
  import sprot_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int MAX_HOLD = 255,
  localparam int IDW      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               bus_done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     gnt_id,
  output logic               bus_busy,
  output logic               timeout_err
);

  sprot_arb_state_e   state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [IDW-1:0]     gnt_id_q;
  logic               bus_busy_q;
  logic [IDW-1:0]     rr_ptr_q;

  logic [IDW-1:0]     pick_id;
  logic               pick_any;
  logic [IDW-1:0]     rr_ptr_d;
  logic               release_d;
  logic               force_d;

  sprot_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .winner (pick_id),
    .any    (pick_any)
  );

  // Normal release: transfer done or owner withdrew (both together = one release).
  assign release_d = bus_done || !req[gnt_id_q];
  // Next round starts just past the outgoing owner.
  assign rr_ptr_d  = (gnt_id_q == IDW'(NUM_REQ - 1)) ? '0 : gnt_id_q + IDW'(1);

`ifdef SPROT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] hold_cnt_q;
  logic          timeout_err_q;
  assign force_d     = (hold_cnt_q == CW'(MAX_HOLD)) && !release_d;
  assign timeout_err = timeout_err_q;
`else
  assign force_d     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      bus_busy_q <= 1'b0;
      rr_ptr_q   <= '0;
`ifdef SPROT_ARB_TIMEOUT_EN
      hold_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
`ifdef SPROT_ARB_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
      case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            gnt_q      <= NUM_REQ'(1) << pick_id;
            gnt_id_q   <= pick_id;
            bus_busy_q <= 1'b1;
            state_q    <= ARB_OWN;
`ifdef SPROT_ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
`endif
          end
        end
        ARB_OWN: begin
          if (release_d || force_d) begin
            gnt_q      <= '0;
            bus_busy_q <= 1'b0;
            rr_ptr_q   <= rr_ptr_d;
            state_q    <= ARB_RELEASE;
`ifdef SPROT_ARB_TIMEOUT_EN
            timeout_err_q <= force_d;
`endif
          end else begin
`ifdef SPROT_ARB_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_q + CW'(1);
`endif
          end
        end
        // Bus turnaround: no grant for one cycle.
        ARB_RELEASE: state_q <= ARB_IDLE;
        default:     state_q <= ARB_IDLE;
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign gnt_id   = gnt_id_q;
  assign bus_busy = bus_busy_q;

endmodule

// File: tb/tb_sprot_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sprot_bus_arbiter
// Directed scenarios plus randomized traffic, every cycle compared against a
// behavioural ownership model (owner index, round-robin pointer, turnaround).
// ---------------------------------------------------------------------------
module tb_sprot_bus_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int IDW      = $clog2(N);
`ifdef SPROT_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic           bus_done;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           bus_busy;
  logic           timeout_err;

  sprot_bus_arbiter #(.NUM_REQ(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .bus_done    (bus_done),
    .gnt         (gnt),
    .gnt_id      (gnt_id),
    .bus_busy    (bus_busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Behavioural model: who owns the bus, where the next search starts.
  int m_owner = -1;  // -1 = nobody
  int m_ptr   = 0;
  int m_last  = 0;
  int m_turn  = 0;   // 1 during the turnaround cycle
  int m_age   = 0;   // owned cycles already completed
  int m_terr  = 0;

  task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_step();
    m_terr = 0;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_last = 0; m_turn = 0; m_age = 0;
    end else if (m_owner >= 0) begin
      if (!req[m_owner] || bus_done) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_turn = 1;
      end else if (TO_EN && m_age == MAX_HOLD) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_turn = 1; m_terr = 1;
      end else begin
        m_age++;
      end
    end else if (m_turn != 0) begin
      m_turn = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (req[c]) begin
          m_owner = c; m_last = c; m_age = 0;
          break;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [31:0] exp_gnt;
    exp_gnt = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    check_eq("gnt", 32'(gnt), exp_gnt);
    check_eq("gnt_id", 32'(gnt_id), 32'(m_last));
    check_eq("bus_busy", 32'(bus_busy), 32'(m_owner >= 0));
    check_eq("timeout_err", 32'(timeout_err), 32'(m_terr));
    check_eq("onehot0", 32'($onehot0(gnt)), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; bus_done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    int g_cyc;
    int done_cyc;
    int waited;
    int terr_seen;
    int gnt_gap;

    rst = 1'b1; req = '0; bus_done = 1'b0;
    tick(); tick();
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_busy", 32'(bus_busy), 32'd0);
    rst = 1'b0;

    // 1: single requester, done at t+5
    tick();
    req = 4'b0100;              // cycle t
    tick();                     // t+1
    check_eq("t1_gnt", 32'(gnt), 32'h4);
    check_eq("t1_id", 32'(gnt_id), 32'd2);
    check_eq("t1_busy", 32'(bus_busy), 32'd1);
    tick(); tick(); tick(); tick();  // t+5
    bus_done = 1'b1;
    tick();                     // t+6
    bus_done = 1'b0;
    check_eq("t1_gnt_clr", 32'(gnt), 32'd0);
    check_eq("t1_busy_clr", 32'(bus_busy), 32'd0);
    req = '0;
    tick();

    // 2: all requesting, done two cycles after each grant
    do_reset();
    req = 4'b1111;
    done_cyc = 0;
    for (int i = 0; i < 5; i++) begin
      waited = 0;
      while (!bus_busy && waited < 10) begin tick(); waited++; end
      check_eq("t2_grant_wait", 32'(bus_busy), 32'd1);
      g_cyc = cyc;
      $display("grant %0d: id=%0d cyc=%0d", i, gnt_id, g_cyc);
      check_eq("t2_order", 32'(gnt_id), 32'(exp_order[i]));
      if (i > 0) check_eq("t2_spacing", 32'(g_cyc - done_cyc), 32'd3);
      tick(); tick();
      bus_done = 1'b1; done_cyc = cyc;
      tick();
      bus_done = 1'b0;
    end
    req = '0; tick(); tick();

    // 3: owner withdraws, pointer wraps to 0
    do_reset();
    req = 4'b0010; tick(); tick();
    check_eq("t3_own1", 32'(gnt_id), 32'd1);
    req = 4'b0001; tick();
    check_eq("t3_gnt_clr", 32'(gnt), 32'd0);
    req = 4'b0011; tick(); tick();
    check_eq("t3_wrap_id", 32'(gnt_id), 32'd0);
    req = '0; tick(); tick(); tick();

    // 4: done and withdraw together advance pointer once
    do_reset();
    req = 4'b0100; tick();
    req = 4'b0000; bus_done = 1'b1; tick();
    bus_done = 1'b0; req = 4'b1111; tick(); tick();
    check_eq("t4_next_id", 32'(gnt_id), 32'd3);
    req = '0; tick(); tick(); tick();

    // 5: reset while owning
    req = 4'b0001; tick(); tick();
    rst = 1'b1; tick();
    check_eq("t5_gnt", 32'(gnt), 32'd0);
    check_eq("t5_id", 32'(gnt_id), 32'd0);
    check_eq("t5_busy", 32'(bus_busy), 32'd0);
    rst = 1'b0; req = 4'b1000; tick();
    check_eq("t5_id3", 32'(gnt_id), 32'd3);
    req = '0; tick(); tick(); tick();

    // 6: owner never completes
    do_reset();
    req = 4'b0001; tick();
    terr_seen = 0; gnt_gap = 0;
    for (int i = 0; i < 110; i++) begin
      tick();
      if (timeout_err) terr_seen++;
      if (gnt == '0) gnt_gap++;
    end
    check_eq("t6_terr_seen", 32'(terr_seen != 0), 32'(TO_EN));
    check_eq("t6_gnt_gap", 32'(gnt_gap != 0), 32'(TO_EN));
    req = '0; tick(); tick(); tick();

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 2) == 0) req = N'($urandom);
      bus_done = ($urandom_range(0, 3) == 0);
      tick();
    end
    rst = 1'b0; req = '0; bus_done = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
